// File: rtl/move_cmd_exec.sv
// -----------------------------------------------------------------------------
// move_cmd_exec
//   Executes one motion command at a time.
//   - Calibration: pulses strt_cal and waits for cal_done.
//   - Move: loads the desired heading, waits in TURN until the heading
//     error is small, then ramps forward speed up. It counts centre-line
//     IR crossings (2 per square) and ramps down to zero when the count
//     reaches the target. It acknowledges completion with send_resp.
//   - Any other opcode is accepted and dropped.
//
// Optional feature macro: FANFARE_EN
//   When defined, opcode 4'h5 also pulses fanfare in the DONE cycle.
//   When undefined, fanfare is tied low and opcode 4'h5 behaves as 4'h4.
//
// Ports
//   clk          in   clock
//   rst_n        in   asynchronous active-low reset
//   cmd[15:0]    in   [15:12] opcode, [11:4] heading, [3:0] squares
//   cmd_rdy      in   command valid
//   clr_cmd_rdy  out  command accepted (combinational, IDLE only)
//   send_resp    out  command complete pulse
//   cal_done     in   gyro calibration finished
//   strt_cal     out  calibration start pulse
//   heading_rdy  in   new heading sample strobe
//   hdng_err     in   signed heading error
//   cntrIR       in   centre-line IR sensor (asynchronous)
//   moving       out  motion active
//   frwrd_spd    out  forward speed
//   dsrd_hdng    out  desired heading
//   fanfare      out  fanfare start pulse
// -----------------------------------------------------------------------------
module move_cmd_exec #(
  parameter logic [9:0]  SPD_INC    = 10'h018,
  parameter logic [9:0]  MAX_SPD    = 10'h2A0,
  parameter logic [11:0] ERR_THRESH = 12'h030
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [15:0]        cmd,
  input  logic               cmd_rdy,
  output logic               clr_cmd_rdy,
  output logic               send_resp,
  input  logic               cal_done,
  output logic               strt_cal,
  input  logic               heading_rdy,
  input  logic signed [11:0] hdng_err,
  input  logic               cntrIR,
  output logic               moving,
  output logic [9:0]         frwrd_spd,
  output logic [11:0]        dsrd_hdng,
  output logic               fanfare
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CAL       = 3'd1,
    TURN      = 3'd2,
    RAMP_UP   = 3'd3,
    RAMP_DOWN = 3'd4,
    DONE      = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [9:0]  spd_q, spd_d;
  logic [11:0] hdng_q, hdng_d;
  logic [3:0]  sq_q, sq_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [2:0]  sync_q;

  logic        accept;
  logic        is_move;
  logic        line_rise;
  logic        err_ok;
  logic [11:0] err_mag;

  // Speed step up, clamped at MAX_SPD; computed one bit wider so the
  // addition can never wrap.
  function automatic logic [9:0] sat_up(input logic [9:0] spd);
    logic [10:0] sum;
    sum = {1'b0, spd} + {1'b0, SPD_INC};
    if (sum > {1'b0, MAX_SPD}) return MAX_SPD;
    return sum[9:0];
  endfunction

  // Speed step down by twice the ramp step, clamped at zero.
  function automatic logic [9:0] sat_dn(input logic [9:0] spd);
    logic [10:0] dec;
    dec = {SPD_INC, 1'b0};
    if ({1'b0, spd} <= dec) return 10'h000;
    return spd - dec[9:0];
  endfunction

  assign accept    = (state_q == IDLE) && cmd_rdy;
  assign is_move   = (cmd[15:12] == 4'h4) || (cmd[15:12] == 4'h5);
  // -(-2048) is 12'h800, which is the correct magnitude when read unsigned.
  assign err_mag   = hdng_err[11] ? $unsigned(-hdng_err) : $unsigned(hdng_err);
  assign err_ok    = err_mag < ERR_THRESH;
  assign line_rise = sync_q[1] & ~sync_q[2];

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_rdy) begin
          if (cmd[15:12] == 4'h2) state_d = CAL;
          else if (is_move)       state_d = TURN;
        end
      end
      CAL:       if (cal_done) state_d = DONE;
      TURN:      if (heading_rdy && err_ok) state_d = (sq_q != 4'h0) ? RAMP_UP : DONE;
      RAMP_UP:   if (cnt_q == {sq_q, 1'b0}) state_d = RAMP_DOWN;
      RAMP_DOWN: if (spd_q == 10'h000) state_d = DONE;
      DONE:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------------
  // clr_cmd_rdy and strt_cal depend on cmd_rdy directly, so they are also
  // qualified by rst_n to stay low while reset is held.
  always_comb begin
    clr_cmd_rdy = rst_n && accept;
    strt_cal    = rst_n && accept && (cmd[15:12] == 4'h2);
    send_resp   = (state_q == DONE);
    moving      = (state_q == TURN) || (state_q == RAMP_UP) ||
                  (state_q == RAMP_DOWN);
  end

  // ---------------------------------------------------------------------------
  // Datapath next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    unique case (state_q)
      RAMP_UP:   spd_d = heading_rdy ? sat_up(spd_q) : spd_q;
      RAMP_DOWN: spd_d = heading_rdy ? sat_dn(spd_q) : spd_q;
      default:   spd_d = 10'h000;
    endcase

    hdng_d = hdng_q;
    if (accept && is_move)
      hdng_d = (cmd[11:4] != 8'h00) ? {cmd[11:4], 4'hF} : 12'h000;

    sq_d = accept ? cmd[3:0] : sq_q;

    // A crossing coinciding with accept is dropped: the count starts fresh.
    if (accept)         cnt_d = 5'd0;
    else if (line_rise) cnt_d = cnt_q + 5'd1;
    else                cnt_d = cnt_q;
  end

  // ---------------------------------------------------------------------------
  // Datapath registers and IR synchroniser
  // ---------------------------------------------------------------------------
  // sync_q[1:0] is the two-flop synchroniser; sync_q[2] is the edge history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spd_q  <= 10'h000;
      hdng_q <= 12'h000;
      sq_q   <= 4'h0;
      cnt_q  <= 5'd0;
      sync_q <= 3'b000;
    end else begin
      spd_q  <= spd_d;
      hdng_q <= hdng_d;
      sq_q   <= sq_d;
      cnt_q  <= cnt_d;
      sync_q <= {sync_q[1:0], cntrIR};
    end
  end

  assign frwrd_spd = spd_q;
  assign dsrd_hdng = hdng_q;

`ifdef FANFARE_EN
  logic fan_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      fan_q <= 1'b0;
    else if (accept) fan_q <= (cmd[15:12] == 4'h5);
  end

  assign fanfare = (state_q == DONE) && fan_q;
`else
  assign fanfare = 1'b0;
`endif

endmodule

// File: tb/tb_move_cmd_exec.sv
module tb_move_cmd_exec;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        send_resp;
  logic        cal_done;
  logic        strt_cal;
  logic        heading_rdy;
  logic [11:0] hdng_err;
  logic        cntrIR;
  logic        moving;
  logic [9:0]  frwrd_spd;
  logic [11:0] dsrd_hdng;
  logic        fanfare;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef FANFARE_EN
  localparam logic EXP_FAN = 1'b1;
`else
  localparam logic EXP_FAN = 1'b0;
`endif

  move_cmd_exec dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd         (cmd),
    .cmd_rdy     (cmd_rdy),
    .clr_cmd_rdy (clr_cmd_rdy),
    .send_resp   (send_resp),
    .cal_done    (cal_done),
    .strt_cal    (strt_cal),
    .heading_rdy (heading_rdy),
    .hdng_err    (hdng_err),
    .cntrIR      (cntrIR),
    .moving      (moving),
    .frwrd_spd   (frwrd_spd),
    .dsrd_hdng   (dsrd_hdng),
    .fanfare     (fanfare)
  );

  always #5 clk = ~clk;

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic hr_pulse();
    heading_rdy = 1'b1;
    step();
    heading_rdy = 1'b0;
  endtask

  task automatic test_reset();
    cmd = 16'h2000; cmd_rdy = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (clr_cmd_rdy !== 1'b0) begin n_fail++; $display("FAIL rst_clr: got %b want 0", clr_cmd_rdy); end
    n_checks++; if (strt_cal !== 1'b0) begin n_fail++; $display("FAIL rst_strt_cal: got %b want 0", strt_cal); end
    n_checks++; if (send_resp !== 1'b0) begin n_fail++; $display("FAIL rst_send_resp: got %b want 0", send_resp); end
    n_checks++; if (moving !== 1'b0) begin n_fail++; $display("FAIL rst_moving: got %b want 0", moving); end
    n_checks++; if (fanfare !== 1'b0) begin n_fail++; $display("FAIL rst_fanfare: got %b want 0", fanfare); end
    n_checks++; if (frwrd_spd !== 10'h000) begin n_fail++; $display("FAIL rst_spd: got %h want 000", frwrd_spd); end
    n_checks++; if (dsrd_hdng !== 12'h000) begin n_fail++; $display("FAIL rst_hdng: got %h want 000", dsrd_hdng); end
    step(2);
    cmd_rdy = 1'b0;
    rst_n = 1'b1;
    step(2);
  endtask

  task automatic test_cal();
    cmd = 16'h2000; cmd_rdy = 1'b1;
    #1;
    n_checks++; if (clr_cmd_rdy !== 1'b1) begin n_fail++; $display("FAIL cal_clr: got %b want 1", clr_cmd_rdy); end
    n_checks++; if (strt_cal !== 1'b1) begin n_fail++; $display("FAIL cal_strt: got %b want 1", strt_cal); end
    step();
    cmd_rdy = 1'b0;
    #1;
    n_checks++; if (clr_cmd_rdy !== 1'b0) begin n_fail++; $display("FAIL cal_clr_after: got %b want 0", clr_cmd_rdy); end
    n_checks++; if (strt_cal !== 1'b0) begin n_fail++; $display("FAIL cal_strt_after: got %b want 0", strt_cal); end
    for (int i = 0; i < 10; i++) begin
      n_checks++; if (send_resp !== 1'b0 || moving !== 1'b0) begin n_fail++; $display("FAIL cal_wait: resp=%b moving=%b want 0/0", send_resp, moving); end
      step();
    end
    cal_done = 1'b1;
    step();
    cal_done = 1'b0;
    n_checks++; if (send_resp !== 1'b1) begin n_fail++; $display("FAIL cal_resp: got %b want 1", send_resp); end
    n_checks++; if (fanfare !== 1'b0) begin n_fail++; $display("FAIL cal_fanfare: got %b want 0", fanfare); end
    step();
    n_checks++; if (send_resp !== 1'b0) begin n_fail++; $display("FAIL cal_resp_end: got %b want 0", send_resp); end
    step();
  endtask

  task automatic test_turn_fanfare();
    cmd = 16'h5BF1; cmd_rdy = 1'b1;
    #1;
    n_checks++; if (clr_cmd_rdy !== 1'b1) begin n_fail++; $display("FAIL turn_clr: got %b want 1", clr_cmd_rdy); end
    step();
    cmd_rdy = 1'b0;
    n_checks++; if (dsrd_hdng !== 12'hBFF) begin n_fail++; $display("FAIL turn_hdng: got %h want BFF", dsrd_hdng); end
    n_checks++; if (moving !== 1'b1) begin n_fail++; $display("FAIL turn_moving: got %b want 1", moving); end
    // Large or boundary errors (100, -100, 030, -030) must hold TURN.
    hdng_err = 12'h100; hr_pulse(); step(3);
    hdng_err = 12'hF00; hr_pulse(); step(3);
    hdng_err = 12'h030; hr_pulse(); step(3);
    hdng_err = 12'hFD0; hr_pulse(); step(3);
    n_checks++; if (frwrd_spd !== 10'h000 || moving !== 1'b1) begin n_fail++; $display("FAIL turn_hold: spd=%h moving=%b want 000/1", frwrd_spd, moving); end
    hdng_err = 12'h010; hr_pulse();
    // Transition pulse itself must not ramp.
    n_checks++; if (frwrd_spd !== 10'h000) begin n_fail++; $display("FAIL turn_exit_spd: got %h want 000", frwrd_spd); end
    step(3);
    hr_pulse();
    n_checks++; if (frwrd_spd !== 10'h018) begin n_fail++; $display("FAIL turn_ramp1: got %h want 018", frwrd_spd); end
    step(3);
    // First line crossing lands on the same edge as a heading strobe.
    cntrIR = 1'b1; step(2);
    hr_pulse();
    cntrIR = 1'b0;
    n_checks++; if (frwrd_spd !== 10'h030) begin n_fail++; $display("FAIL turn_coinc: got %h want 030", frwrd_spd); end
    step(3);
    cntrIR = 1'b1; step(3);
    cntrIR = 1'b0; step(3);
    n_checks++; if (frwrd_spd !== 10'h030 || moving !== 1'b1 || send_resp !== 1'b0) begin n_fail++; $display("FAIL turn_pre_down: spd=%h moving=%b resp=%b want 030/1/0", frwrd_spd, moving, send_resp); end
    hr_pulse();
    n_checks++; if (frwrd_spd !== 10'h000 || send_resp !== 1'b0) begin n_fail++; $display("FAIL turn_down0: spd=%h resp=%b want 000/0", frwrd_spd, send_resp); end
    step();
    n_checks++; if (send_resp !== 1'b1) begin n_fail++; $display("FAIL turn_resp: got %b want 1", send_resp); end
    n_checks++; if (fanfare !== EXP_FAN) begin n_fail++; $display("FAIL turn_fanfare: got %b want %b", fanfare, EXP_FAN); end
    step();
    n_checks++; if (send_resp !== 1'b0 || fanfare !== 1'b0 || moving !== 1'b0) begin n_fail++; $display("FAIL turn_end: resp=%b fan=%b moving=%b want 0/0/0", send_resp, fanfare, moving); end
    hdng_err = 12'h000;
    step();
  endtask

  task automatic test_back_to_back();
    // Zero-square move with zero heading, while a stray command waits.
    cmd = 16'h4000; cmd_rdy = 1'b1;
    #1;
    n_checks++; if (clr_cmd_rdy !== 1'b1) begin n_fail++; $display("FAIL b2b_clr: got %b want 1", clr_cmd_rdy); end
    step();
    cmd = 16'hF000;
    #1;
    n_checks++; if (dsrd_hdng !== 12'h000) begin n_fail++; $display("FAIL b2b_hdng: got %h want 000", dsrd_hdng); end
    n_checks++; if (clr_cmd_rdy !== 1'b0 || moving !== 1'b1) begin n_fail++; $display("FAIL b2b_busy: clr=%b moving=%b want 0/1", clr_cmd_rdy, moving); end
    step(2);
    hr_pulse();
    n_checks++; if (send_resp !== 1'b1 || frwrd_spd !== 10'h000) begin n_fail++; $display("FAIL b2b_resp: resp=%b spd=%h want 1/000", send_resp, frwrd_spd); end
    n_checks++; if (clr_cmd_rdy !== 1'b0) begin n_fail++; $display("FAIL b2b_clr_done: got %b want 0", clr_cmd_rdy); end
    step();
    // Back in IDLE: the pending unknown opcode is accepted now.
    n_checks++; if (clr_cmd_rdy !== 1'b1 || send_resp !== 1'b0) begin n_fail++; $display("FAIL b2b_accept: clr=%b resp=%b want 1/0", clr_cmd_rdy, send_resp); end
    step();
    cmd_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (send_resp !== 1'b0 || moving !== 1'b0 || strt_cal !== 1'b0) begin n_fail++; $display("FAIL b2b_unk: resp=%b moving=%b cal=%b want 0/0/0", send_resp, moving, strt_cal); end
      step();
    end
    n_checks++; if (dsrd_hdng !== 12'h000) begin n_fail++; $display("FAIL b2b_hdng_keep: got %h want 000", dsrd_hdng); end
  endtask

  task automatic test_ramp();
    logic [9:0] exp_spd;
    cmd = 16'h4002; cmd_rdy = 1'b1; hdng_err = 12'h000;
    step();
    cmd_rdy = 1'b0;
    n_checks++; if (dsrd_hdng !== 12'h000 || moving !== 1'b1) begin n_fail++; $display("FAIL ramp_start: hdng=%h moving=%b want 000/1", dsrd_hdng, moving); end
    hr_pulse();
    n_checks++; if (frwrd_spd !== 10'h000) begin n_fail++; $display("FAIL ramp_turn_exit: got %h want 000", frwrd_spd); end
    step(3);
    for (int k = 1; k <= 29; k++) begin
      exp_spd = (k >= 28) ? 10'h2A0 : 10'(24 * k);
      hr_pulse();
      n_checks++; if (frwrd_spd !== exp_spd) begin n_fail++; $display("FAIL ramp_up_%0d: got %h want %h", k, frwrd_spd, exp_spd); end
      step(3);
    end
    for (int e = 0; e < 4; e++) begin
      cntrIR = 1'b1; step(3);
      cntrIR = 1'b0; step(3);
    end
    n_checks++; if (frwrd_spd !== 10'h2A0 || moving !== 1'b1) begin n_fail++; $display("FAIL ramp_peak: spd=%h moving=%b want 2A0/1", frwrd_spd, moving); end
    for (int k = 1; k <= 14; k++) begin
      exp_spd = 10'(672 - 48 * k);
      hr_pulse();
      n_checks++; if (frwrd_spd !== exp_spd || send_resp !== 1'b0) begin n_fail++; $display("FAIL ramp_down_%0d: spd=%h resp=%b want %h/0", k, frwrd_spd, send_resp, exp_spd); end
      if (k < 14) step(3);
    end
    n_checks++; if (moving !== 1'b1) begin n_fail++; $display("FAIL ramp_zero_moving: got %b want 1", moving); end
    step();
    n_checks++; if (send_resp !== 1'b1 || moving !== 1'b0) begin n_fail++; $display("FAIL ramp_resp: resp=%b moving=%b want 1/0", send_resp, moving); end
    n_checks++; if (fanfare !== 1'b0) begin n_fail++; $display("FAIL ramp_fanfare: got %b want 0", fanfare); end
    step();
    n_checks++; if (send_resp !== 1'b0) begin n_fail++; $display("FAIL ramp_resp_end: got %b want 0", send_resp); end
    step();
  endtask

  task automatic test_reset_mid_move();
    cmd = 16'h4033; cmd_rdy = 1'b1; hdng_err = 12'h000;
    step();
    cmd_rdy = 1'b0;
    n_checks++; if (dsrd_hdng !== 12'h03F) begin n_fail++; $display("FAIL mid_hdng: got %h want 03F", dsrd_hdng); end
    hr_pulse(); step(3);
    for (int k = 0; k < 8; k++) begin
      hr_pulse(); step(3);
    end
    n_checks++; if (frwrd_spd !== 10'h0C0 || moving !== 1'b1) begin n_fail++; $display("FAIL mid_spd: spd=%h moving=%b want 0C0/1", frwrd_spd, moving); end
    cmd_rdy = 1'b1;
    rst_n = 1'b0;
    #1;
    n_checks++; if (frwrd_spd !== 10'h000 || dsrd_hdng !== 12'h000) begin n_fail++; $display("FAIL mid_rst_data: spd=%h hdng=%h want 000/000", frwrd_spd, dsrd_hdng); end
    n_checks++; if (moving !== 1'b0 || send_resp !== 1'b0 || clr_cmd_rdy !== 1'b0 || strt_cal !== 1'b0 || fanfare !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ctl: mv=%b resp=%b clr=%b cal=%b fan=%b want all 0", moving, send_resp, clr_cmd_rdy, strt_cal, fanfare); end
    step(2);
    cmd_rdy = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      n_checks++; if (send_resp !== 1'b0 || moving !== 1'b0) begin n_fail++; $display("FAIL mid_after: resp=%b moving=%b want 0/0", send_resp, moving); end
    end
  endtask

  initial begin
    rst_n = 1'b1; cmd = 16'h0000; cmd_rdy = 1'b0; cal_done = 1'b0;
    heading_rdy = 1'b0; hdng_err = 12'h000; cntrIR = 1'b0;
    test_reset();
    test_cal();
    test_turn_fanfare();
    test_back_to_back();
    test_ramp();
    test_reset_mid_move();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
